// File: rtl/data_modulate_3x3_sequencer.sv
// data_modulate_3x3_sequencer
// Frame sequencer for a 3x3 window datapath: tracks the raster position of incoming
// pixels, selects the line buffer to write and strobes each valid window centre.
// Optional feature macro: DATA_MODULATE_3X3_ZERO_PAD_EN (every pixel becomes a centre,
// border windows flagged on pad_o, trailing centres drained in a FLUSH state).
module data_modulate_3x3_sequencer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned CW     = $clog2(WIDTH),
    parameter int unsigned RW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          valid_i,
    output logic [1:0]    lb_sel_o,
    output logic          busy_o,
    output logic          win_valid_o,
    output logic [RW-1:0] win_row_o,
    output logic [CW-1:0] win_col_o,
    output logic [3:0]    pad_o,
    output logic          done_o
);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    // FIN holds the done_o cycle so start_i coincident with done_o is not honoured
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2, FLUSH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
`endif

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          row_end;
    logic          last_pix;
    logic          issue;
    logic          issue_last;
    logic [RW-1:0] issue_row;
    logic [CW-1:0] issue_col;

    assign accept   = (state == RUN) && valid_i;
    assign row_end  = (col == COL_LAST);
    assign last_pix = row_end && (row == ROW_LAST);

`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
    localparam int unsigned PW = $clog2(WIDTH * HEIGHT + 1);

    logic [RW-1:0] crow;
    logic [CW-1:0] ccol;
    logic [PW-1:0] pix_cnt;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] need;
    logic [RW-1:0] need_row;
    logic [CW-1:0] need_col;
    logic [3:0]    issue_pad;

    // Next centre is issuable once its bottom-right neighbour (clamped to the frame) has arrived
    always_comb begin
        need_row   = (crow == ROW_LAST) ? crow : crow + RW'(1);
        need_col   = (ccol == COL_LAST) ? ccol : ccol + CW'(1);
        need       = PW'(need_row) * PW'(WIDTH) + PW'(need_col);
        cnt_next   = pix_cnt + PW'(accept);
        issue      = ((state == RUN) || (state == FLUSH)) && (cnt_next > need);
        issue_last = (crow == ROW_LAST) && (ccol == COL_LAST);
        issue_row  = crow;
        issue_col  = ccol;
        issue_pad  = {crow == '0, crow == ROW_LAST, ccol == '0, ccol == COL_LAST};
    end
`else
    // Window centre trails the accepted pixel by one row and one column
    always_comb begin
        issue      = accept && (row >= RW'(2)) && (col >= CW'(2));
        issue_last = last_pix;
        issue_row  = row - RW'(1);
        issue_col  = col - CW'(1);
    end

    assign pad_o = 4'b0000;
`endif

    // Frame FSM, pixel/centre counters, line-buffer select and registered window outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            lb_sel_o    <= 2'b01;
            busy_o      <= 1'b0;
            win_valid_o <= 1'b0;
            win_row_o   <= '0;
            win_col_o   <= '0;
            done_o      <= 1'b0;
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
            crow        <= '0;
            ccol        <= '0;
            pix_cnt     <= '0;
            pad_o       <= 4'b0000;
`endif
        end else begin
            win_valid_o <= 1'b0;
            done_o      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                        row    <= '0;
                        col    <= '0;
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
                        crow    <= '0;
                        ccol    <= '0;
                        pix_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    if (accept && last_pix) begin
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
                        state <= FLUSH;
`else
                        state <= FIN;
`endif
                    end
                end
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
                FLUSH: begin
                    if (issue && issue_last) begin
                        state <= FIN;
                    end
                end
`endif
                FIN: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (row_end) begin
                    col      <= '0;
                    row      <= (row == ROW_LAST) ? '0 : row + RW'(1);
                    lb_sel_o <= {lb_sel_o[0], lb_sel_o[1]};
                end else begin
                    col <= col + CW'(1);
                end
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
                pix_cnt <= cnt_next;
`endif
            end

            if (issue) begin
                win_valid_o <= 1'b1;
                win_row_o   <= issue_row;
                win_col_o   <= issue_col;
                done_o      <= issue_last;
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
                pad_o       <= issue_pad;
                if (ccol == COL_LAST) begin
                    ccol <= '0;
                    crow <= (crow == ROW_LAST) ? '0 : crow + RW'(1);
                end else begin
                    ccol <= ccol + CW'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_modulate_3x3_sequencer.sv
// Bench for data_modulate_3x3_sequencer on a 4x4 frame, both build flavours
// (DATA_MODULATE_3X3_ZERO_PAD_EN selects the padded expectations).
module tb_data_modulate_3x3_sequencer;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int TOTAL = PAD ? W * H : (W - 2) * (H - 2);

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_FIN   = 3;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          valid_i;
    logic [1:0]    lb_sel_o;
    logic          busy_o;
    logic          win_valid_o;
    logic [RW-1:0] win_row_o;
    logic [CW-1:0] win_col_o;
    logic [3:0]    pad_o;
    logic          done_o;

    data_modulate_3x3_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .lb_sel_o    (lb_sel_o),
        .busy_o      (busy_o),
        .win_valid_o (win_valid_o),
        .win_row_o   (win_row_o),
        .win_col_o   (win_col_o),
        .pad_o       (pad_o),
        .done_o      (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state: pixels accepted (n) and windows issued (k) in the frame
    int         m_mode;
    int         n;
    int         k;
    bit         m_acc;
    bit         m_valid;
    bit         m_done;
    bit         m_busy;
    int         m_row;
    int         m_col;
    logic [3:0] m_pad;
    logic [1:0] m_lb;

    // Literal expectations requested by the stimulus for the next falling edge
    bit         lit_req;
    bit         lit_valid;
    int         lit_row;
    int         lit_col;
    logic [3:0] lit_pad;
    bit         lit_done;
    bit         lit_busy;
    logic [1:0] lit_lb;

    function automatic int c_row(input int j);
        if (PAD) return j / W;
        return 1 + j / (W - 2);
    endfunction

    function automatic int c_col(input int j);
        if (PAD) return j % W;
        return 1 + j % (W - 2);
    endfunction

    // Raster index of the pixel whose arrival makes centre j available
    function automatic int enable_idx(input int j);
        int r;
        int c;
        r = c_row(j);
        c = c_col(j);
        if (PAD) return ((r + 1 < H) ? r + 1 : H - 1) * W + ((c + 1 < W) ? c + 1 : W - 1);
        return (r + 1) * W + (c + 1);
    endfunction

    function automatic logic [3:0] pad_of(input int j);
        int r;
        int c;
        r = c_row(j);
        c = c_col(j);
        if (!PAD) return 4'b0000;
        return {r == 0, r == H - 1, c == 0, c == W - 1};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  = M_IDLE;
            n       = 0;
            k       = 0;
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_busy  = 1'b0;
            m_row   = 0;
            m_col   = 0;
            m_pad   = 4'b0000;
            m_lb    = 2'b01;
        end else begin
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_acc   = (m_mode == M_RUN) && valid_i;
            if (m_mode == M_IDLE) begin
                if (start_i) begin
                    m_mode = M_RUN;
                    m_busy = 1'b1;
                    n      = 0;
                    k      = 0;
                end
            end else if (m_mode == M_FIN) begin
                m_mode = M_IDLE;
                m_busy = 1'b0;
            end else begin
                if (m_acc) begin
                    n = n + 1;
                    if (n % W == 0) m_lb = {m_lb[0], m_lb[1]};
                end
                if (k < TOTAL && enable_idx(k) < n) begin
                    m_valid = 1'b1;
                    m_row   = c_row(k);
                    m_col   = c_col(k);
                    m_pad   = pad_of(k);
                    k       = k + 1;
                    if (k == TOTAL) begin
                        m_done = 1'b1;
                        m_mode = M_FIN;
                    end
                end
                if (m_acc && n == W * H && m_mode == M_RUN) m_mode = M_FLUSH;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, and against literals when requested
    always @(negedge clk) begin
        chk("busy", int'(busy_o), int'(m_busy));
        chk("lb_sel", int'(lb_sel_o), int'(m_lb));
        chk("win_valid", int'(win_valid_o), int'(m_valid));
        chk("done", int'(done_o), int'(m_done));
        if (m_valid) begin
            chk("win_row", int'(win_row_o), m_row);
            chk("win_col", int'(win_col_o), m_col);
            chk("pad", int'(pad_o), int'(m_pad));
        end
        if (lit_req) begin
            chk("lit_busy", int'(busy_o), int'(lit_busy));
            chk("lit_lb_sel", int'(lb_sel_o), int'(lit_lb));
            chk("lit_win_valid", int'(win_valid_o), int'(lit_valid));
            chk("lit_done", int'(done_o), int'(lit_done));
            if (lit_valid) begin
                chk("lit_win_row", int'(win_row_o), lit_row);
                chk("lit_win_col", int'(win_col_o), lit_col);
                chk("lit_pad", int'(pad_o), int'(lit_pad));
            end
        end
    end

    task automatic drive(input bit s, input bit v);
        start_i = s;
        valid_i = v;
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input bit v, input int r, input int c, input logic [3:0] p,
                       input bit d, input bit b, input logic [1:0] lb);
        lit_valid = v;
        lit_row   = r;
        lit_col   = c;
        lit_pad   = p;
        lit_done  = d;
        lit_busy  = b;
        lit_lb    = lb;
        lit_req   = 1'b1;
        @(negedge clk);
        #1;
        lit_req = 1'b0;
    endtask

    task automatic run_frame(input bit gap);
        drive(1'b1, 1'b0);
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < W * H; i++) begin
            drive(i == 5, 1'b1);
            if (i == 3) pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1, 2'b10);
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
            if (i == 5)  pin(1'b1, 0, 0, 4'b1010, 1'b0, 1'b1, 2'b10);
            if (i == 7)  pin(1'b1, 0, 2, 4'b1000, 1'b0, 1'b1, 2'b01);
            if (i == 15) pin(1'b1, 2, 2, 4'b0000, 1'b0, 1'b1, 2'b01);
`else
            if (i == 7)  pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1, 2'b01);
            if (i == 10) pin(1'b1, 1, 1, 4'b0000, 1'b0, 1'b1, 2'b01);
            if (i == 15) pin(1'b1, 2, 2, 4'b0000, 1'b1, 1'b1, 2'b01);
`endif
            if (gap && i != W * H - 1) drive(1'b0, 1'b0);
        end
`ifdef DATA_MODULATE_3X3_ZERO_PAD_EN
        drive(1'b0, 1'b0);
        pin(1'b1, 2, 3, 4'b0001, 1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b0);
        pin(1'b1, 3, 0, 4'b0110, 1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        pin(1'b1, 3, 3, 4'b0101, 1'b1, 1'b1, 2'b01);
`endif
        drive(1'b1, 1'b0);
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b01);
        drive(1'b0, 1'b1);
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b01);
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        valid_i   = 1'b0;
        lit_req   = 1'b0;
        lit_valid = 1'b0;
        lit_row   = 0;
        lit_col   = 0;
        lit_pad   = 4'b0000;
        lit_done  = 1'b0;
        lit_busy  = 1'b0;
        lit_lb    = 2'b01;
        repeat (2) @(posedge clk);
        #2;
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b01);
        rst = 1'b0;

        // start_i with valid_i in IDLE: pixel not taken, RUN starts next cycle
        drive(1'b1, 1'b1);
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b1, 2'b01);

        // Reset after 7 pixels, then valid_i ignored until a new start_i
        repeat (7) drive(1'b0, 1'b1);
        rst = 1'b1;
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b01);
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b1);
        pin(1'b0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b01);

        run_frame(1'b0);
        run_frame(1'b1);

        repeat (3) drive(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
